// File: rtl/fib_pkg.sv
// Shared types and constants for the Fibonacci index decoder.
package fib_pkg;

   localparam int unsigned WIDTH_DEF      = 20;
   localparam int unsigned IDX_W_DEF      = 8;
   localparam int unsigned FIB_MAX_20     = 832040;
   localparam int unsigned FIB_MAX_IDX_20 = 30;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SEARCH = 2'd1,
      DONE   = 2'd2
   } state_t;

endpackage

// File: rtl/fib_step.sv
// One Fibonacci step: next term and carry out of the WIDTH-bit sum.
module fib_step
   import fib_pkg::*;
#(
   parameter int unsigned WIDTH = WIDTH_DEF
) (
   input  logic [WIDTH-1:0] prev,
   input  logic [WIDTH-1:0] curr,
   output logic [WIDTH-1:0] next_curr,
   output logic             carry
);

   logic [WIDTH:0] sum;

   assign sum       = {1'b0, prev} + {1'b0, curr};
   assign next_curr = sum[WIDTH-1:0];
   assign carry     = sum[WIDTH];

endmodule

// File: rtl/fib_index.sv
// Classifies a value as Fibonacci or not and reports its index by walking the sequence.
module fib_index
   import fib_pkg::*;
#(
   parameter int unsigned WIDTH = WIDTH_DEF,
   parameter int unsigned IDX_W = IDX_W_DEF
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] value,
   output logic             busy,
   output logic             done,
   output logic             is_fib,
   output logic [IDX_W-1:0] index
);

   state_t           state, state_next;
   logic [WIDTH-1:0] target, target_next;
   logic [WIDTH-1:0] prev, prev_next;
   logic [WIDTH-1:0] curr, curr_next;
   logic [IDX_W-1:0] idx, idx_next;
   logic             is_fib_next;
   logic [IDX_W-1:0] index_next;
   logic [WIDTH-1:0] step_curr;
   logic             step_carry;

   fib_step #(
      .WIDTH (WIDTH)
   ) u_step (
      .prev      (prev),
      .curr      (curr),
      .next_curr (step_curr),
      .carry     (step_carry)
   );

   // Next-state, datapath and result logic.
   always_comb begin
      state_next  = state;
      target_next = target;
      prev_next   = prev;
      curr_next   = curr;
      idx_next    = idx;
      is_fib_next = is_fib;
      index_next  = index;

      unique case (state)
         IDLE, DONE: begin
            if (start) begin
               target_next = value;
               state_next  = SEARCH;
               prev_next   = '0;
               // Zero seeds at F(0) so it resolves with the same one-cycle search as value 1.
               if (value == '0) begin
                  curr_next = '0;
                  idx_next  = '0;
               end else begin
                  curr_next = WIDTH'(1);
                  idx_next  = IDX_W'(1);
               end
            end else if (state == DONE) begin
               state_next = IDLE;
            end
         end
         SEARCH: begin
            if (curr == target) begin
               state_next  = DONE;
               is_fib_next = 1'b1;
               index_next  = idx;
            end else if (curr > target) begin
               state_next  = DONE;
               is_fib_next = 1'b0;
               index_next  = idx;
            end else if (step_carry) begin
               state_next  = DONE;
               is_fib_next = 1'b0;
               index_next  = idx + IDX_W'(1);
            end else begin
               prev_next = curr;
               curr_next = step_curr;
               idx_next  = idx + IDX_W'(1);
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // State, datapath and registered outputs.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state  <= IDLE;
         target <= '0;
         prev   <= '0;
         curr   <= '0;
         idx    <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
         is_fib <= 1'b0;
         index  <= '0;
      end else begin
         state  <= state_next;
         target <= target_next;
         prev   <= prev_next;
         curr   <= curr_next;
         idx    <= idx_next;
         busy   <= (state_next == SEARCH);
         done   <= (state_next == DONE);
         is_fib <= is_fib_next;
         index  <= index_next;
      end
   end

endmodule

// File: tb/tb_fib_index.sv
// Directed bench for fib_index: vector table plus handshake and reset sequences.
module tb_fib_index;
   import fib_pkg::*;

   localparam int unsigned W  = WIDTH_DEF;
   localparam int unsigned IW = IDX_W_DEF;

   logic          clock;
   logic          reset;
   logic          start;
   logic [W-1:0]  value;
   logic          busy;
   logic          done;
   logic          is_fib;
   logic [IW-1:0] index;

   int n_cmp;
   int n_bad;

   fib_index #(.WIDTH(W), .IDX_W(IW)) dut (
      .clock  (clock),
      .reset  (reset),
      .start  (start),
      .value  (value),
      .busy   (busy),
      .done   (done),
      .is_fib (is_fib),
      .index  (index)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic [W-1:0]  value;
      logic          exp_is_fib;
      logic [IW-1:0] exp_index;
      int            exp_lat;
   } vec_t;

   vec_t vecs[11];

   task automatic check(input string name, input longint got, input longint exp);
      n_cmp++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   // Called at the negedge after the accepting edge; returns edges until done and busy cycles seen.
   task automatic wait_done(output int lat, output int busy_cnt);
      lat      = 0;
      busy_cnt = 0;
      while (!done && lat < 64) begin
         if (busy) busy_cnt++;
         @(posedge clock);
         lat++;
         @(negedge clock);
      end
   endtask

   task automatic launch(input logic [W-1:0] v);
      start = 1'b1;
      value = v;
      @(posedge clock);
      @(negedge clock);
      start = 1'b0;
      value = '0;
   endtask

   initial begin
      int lat, bcnt, seen_done;
      n_cmp = 0;
      n_bad = 0;
      reset = 1'b1;
      start = 1'b0;
      value = '0;

      vecs[0]  = '{20'd13,      1'b1, 8'd7,  7};
      vecs[1]  = '{20'd14,      1'b0, 8'd8,  8};
      vecs[2]  = '{20'd0,       1'b1, 8'd0,  1};
      vecs[3]  = '{20'd1,       1'b1, 8'd1,  1};
      vecs[4]  = '{20'd2,       1'b1, 8'd3,  3};
      vecs[5]  = '{20'd4,       1'b0, 8'd5,  5};
      vecs[6]  = '{20'd89,      1'b1, 8'd11, 11};
      vecs[7]  = '{20'd100,     1'b0, 8'd12, 12};
      vecs[8]  = '{20'd832040,  1'b1, 8'd30, 30};
      vecs[9]  = '{20'd832041,  1'b0, 8'd31, 30};
      vecs[10] = '{20'd1048575, 1'b0, 8'd31, 30};

      repeat (3) @(negedge clock);
      check("reset_busy",   longint'(busy),   0);
      check("reset_done",   longint'(done),   0);
      check("reset_is_fib", longint'(is_fib), 0);
      check("reset_index",  longint'(index),  0);
      reset = 1'b0;
      @(negedge clock);

      for (int i = 0; i < 11; i++) begin
         launch(vecs[i].value);
         wait_done(lat, bcnt);
         check($sformatf("v%0d_latency", vecs[i].value), longint'(lat), longint'(vecs[i].exp_lat));
         check($sformatf("v%0d_busy_cycles", vecs[i].value), longint'(bcnt), longint'(vecs[i].exp_lat));
         check($sformatf("v%0d_busy_in_done", vecs[i].value), longint'(busy), 0);
         check($sformatf("v%0d_is_fib", vecs[i].value), longint'(is_fib), longint'(vecs[i].exp_is_fib));
         check($sformatf("v%0d_index", vecs[i].value), longint'(index), longint'(vecs[i].exp_index));
         @(negedge clock);
         check($sformatf("v%0d_done_pulse", vecs[i].value), longint'(done), 0);
         check($sformatf("v%0d_hold_index", vecs[i].value), longint'(index), longint'(vecs[i].exp_index));
         check($sformatf("v%0d_hold_is_fib", vecs[i].value), longint'(is_fib), longint'(vecs[i].exp_is_fib));
      end

      // start while busy is ignored
      launch(20'd5);
      @(negedge clock);
      start = 1'b1;
      value = 20'd8;
      @(negedge clock);
      start = 1'b0;
      value = '0;
      wait_done(lat, bcnt);
      check("busy_start_latency", longint'(lat + 2), 5);
      check("busy_start_is_fib",  longint'(is_fib), 1);
      check("busy_start_index",   longint'(index),  5);

      // start during the DONE cycle is taken with no gap
      start = 1'b1;
      value = 20'd2;
      @(posedge clock);
      @(negedge clock);
      start = 1'b0;
      value = '0;
      check("b2b_busy_now", longint'(busy), 1);
      check("b2b_done_low", longint'(done), 0);
      wait_done(lat, bcnt);
      check("b2b_latency", longint'(lat), 3);
      check("b2b_is_fib",  longint'(is_fib), 1);
      check("b2b_index",   longint'(index),  3);
      @(negedge clock);

      // reset mid-search aborts without a done pulse
      launch(20'(FIB_MAX_20));
      seen_done = 0;
      repeat (9) begin
         @(posedge clock);
         #1 if (done) seen_done = 1;
      end
      @(posedge clock);
      #2 reset = 1'b1;
      #1;
      check("abort_busy",   longint'(busy),   0);
      check("abort_done",   longint'(done),   0);
      check("abort_is_fib", longint'(is_fib), 0);
      check("abort_index",  longint'(index),  0);
      repeat (3) begin
         @(negedge clock);
         if (done) seen_done = 1;
      end
      reset = 1'b0;
      repeat (40) begin
         @(negedge clock);
         if (done) seen_done = 1;
      end
      check("abort_no_done", longint'(seen_done), 0);

      launch(20'd3);
      wait_done(lat, bcnt);
      check("post_reset_latency", longint'(lat), 4);
      check("post_reset_is_fib",  longint'(is_fib), 1);
      check("post_reset_index",   longint'(index),  4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
